// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with optional zero register,
// same-cycle write bypass and a one-entry-per-cycle clear engine.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rd_addr        NUM_RD packed read addresses (port k at [k*AW +: AW])
//   rd_data        NUM_RD packed read data (port k at [k*DW +: DW])
//   wr_en/addr/data  write port (accepted when the clear engine is not running)
//   clr_req        start a sequenced clear of the whole array
//   busy           clear engine running
//   clr_done       one-cycle pulse after the last entry is cleared

module regfile_param #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_done
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_ok;
    logic          byp_en;

    // Writes are dropped while clearing and never land in a hardwired zero.
    assign wr_ok = wr_en && (state != CLEAR)
                   && !((ZERO_REG != 0) && (wr_addr == '0));

    // Forwarding only in IDLE and only once reset is released.
    assign byp_en = (BYPASS != 0) && (state == IDLE) && wr_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        clr_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                cnt_nx = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          is_zero;
        logic          hit;

        assign ra      = rd_addr[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit     = byp_en && (wr_addr == ra);

        assign rd_data[k*DW +: DW] = is_zero ? '0      :
                                     hit     ? wr_data :
                                               mem[ra];
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives a default instance and a small 16x8, 4-port,
// no-zero, no-bypass instance against a behavioural array model.

module tb_regfile_param;

    typedef struct {
        logic [63:0] rda;
        logic [63:0] rdb;
        logic [1:0]  bs;
        logic [1:0]  dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic        creq;
    int          ra [2][4];
    int          wa [2];
    logic [31:0] wd [2];

    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  wr_addr_a;
    logic        busy_a;
    logic        done_a;
    logic [11:0] rd_addr_b;
    logic [63:0] rd_data_b;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic        busy_b;
    logic        done_b;

    int          dep [2] = '{32, 8};
    bit          zr  [2] = '{1'b1, 1'b0};
    bit          byp [2] = '{1'b1, 1'b0};

    logic [31:0] m   [2][32];
    int          pos [2];
    bit          dn  [2];

    exp_t        q [$];
    int          total = 0;
    int          bad = 0;
    int          run [2] = '{0, 0};

    always #5 clk = ~clk;

    assign rd_addr_a = {5'(ra[0][1]), 5'(ra[0][0])};
    assign wr_addr_a = 5'(wa[0]);
    assign rd_addr_b = {3'(ra[1][3]), 3'(ra[1][2]), 3'(ra[1][1]), 3'(ra[1][0])};
    assign wr_addr_b = 3'(wa[1]);
    assign wr_data_b = wd[1][15:0];

    regfile_param u_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .wr_en    (wen),
        .wr_addr  (wr_addr_a),
        .wr_data  (wd[0]),
        .clr_req  (creq),
        .busy     (busy_a),
        .clr_done (done_a)
    );

    regfile_param #(
        .DW       (16),
        .AW       (3),
        .NUM_RD   (4),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .wr_en    (wen),
        .wr_addr  (wr_addr_b),
        .wr_data  (wr_data_b),
        .clr_req  (creq),
        .busy     (busy_b),
        .clr_done (done_b)
    );

    function automatic logic [31:0] exp_rd(int i, int k);
        int a;
        a = ra[i][k];
        if (zr[i] && a == 0) return '0;
        if (byp[i] && !rst && pos[i] < 0 && !dn[i] && wen && wa[i] == a)
            return wd[i];
        return m[i][a];
    endfunction

    task automatic edge_model();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int j = 0; j < 32; j++) m[i][j] = '0;
                pos[i] = -1;
                dn[i]  = 1'b0;
            end else if (pos[i] >= 0) begin
                m[i][pos[i]] = '0;
                pos[i]++;
                if (pos[i] == dep[i]) begin
                    pos[i] = -1;
                    dn[i]  = 1'b1;
                end
            end else begin
                if (wen && !(zr[i] && wa[i] == 0)) m[i][wa[i]] = wd[i];
                pos[i] = (!dn[i] && creq) ? 0 : -1;
                dn[i]  = 1'b0;
            end
        end
    endtask

    task automatic step();
        exp_t        e;
        logic [31:0] t0, t1, t2, t3;
        e.rda = {exp_rd(0, 1), exp_rd(0, 0)};
        t0 = exp_rd(1, 0);
        t1 = exp_rd(1, 1);
        t2 = exp_rd(1, 2);
        t3 = exp_rd(1, 3);
        e.rdb = {t3[15:0], t2[15:0], t1[15:0], t0[15:0]};
        e.bs  = {pos[1] >= 0, pos[0] >= 0};
        e.dn  = {dn[1], dn[0]};
        q.push_back(e);
        @(posedge clk);
        edge_model();
        #1;
    endtask

    task automatic rand_rd();
        for (int k = 0; k < 4; k++) begin
            ra[0][k] = $urandom_range(0, 31);
            ra[1][k] = $urandom_range(0, 7);
        end
    endtask

    task automatic rand_in();
        rand_rd();
        wen   = $urandom_range(0, 1) == 1;
        wa[0] = $urandom_range(0, 31);
        wa[1] = $urandom_range(0, 7);
        wd[0] = $urandom;
        wd[1] = $urandom & 32'h0000_ffff;
        creq  = $urandom_range(0, 40) == 0;
        rst   = $urandom_range(0, 300) == 0;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_a", rd_data_a, e.rda);
            chk("rd_b", rd_data_b, e.rdb);
            chk("busy", 64'({busy_b, busy_a}), 64'(e.bs));
            chk("clr_done", 64'({done_b, done_a}), 64'(e.dn));
        end
        // Independent check: a completed clear must have been busy DEPTH cycles.
        if (rst) begin
            run[0] = 0;
            run[1] = 0;
        end else begin
            if (done_a) begin
                chk("busy_len_a", 64'(run[0]), 64'(32));
                run[0] = 0;
            end
            if (done_b) begin
                chk("busy_len_b", 64'(run[1]), 64'(8));
                run[1] = 0;
            end
            if (busy_a) run[0]++;
            if (busy_b) run[1]++;
        end
    end

    initial begin
        rst  = 1'b1;
        wen  = 1'b0;
        creq = 1'b0;
        wa   = '{0, 0};
        wd   = '{32'h0, 32'h0};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 32; j++) m[i][j] = '0;
            for (int k = 0; k < 4; k++) ra[i][k] = 0;
            pos[i] = -1;
            dn[i]  = 1'b0;
        end
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Basic write then read back, unwritten entry reads zero.
        wen = 1'b1;
        wa  = '{5, 5};
        wd  = '{32'hDEADBEEF, 32'h0000BEEF};
        ra[0] = '{6, 6, 0, 0};
        ra[1] = '{6, 6, 6, 6};
        step();
        wen = 1'b0;
        ra[0] = '{5, 5, 0, 0};
        ra[1] = '{5, 5, 6, 0};
        step();
        ra[0] = '{6, 5, 0, 0};
        step();

        // Write to entry 0.
        wen = 1'b1;
        wa  = '{0, 0};
        wd  = '{32'h12345678, 32'h00005678};
        ra[0] = '{0, 0, 0, 0};
        ra[1] = '{0, 0, 0, 0};
        step();
        wen = 1'b0;
        step();
        step();

        // Bypass: old value first, then same-cycle write while reading.
        wen = 1'b1;
        wa  = '{9, 1};
        wd  = '{32'h11111111, 32'h00001111};
        step();
        wd  = '{32'hA5A5A5A5, 32'h0000A5A5};
        ra[0] = '{0, 9, 0, 0};
        ra[1] = '{0, 1, 0, 0};
        step();
        wen = 1'b0;
        step();

        // Fill with index+1, then clear; a write mid-clear is dropped.
        for (int j = 0; j < 32; j++) begin
            wen   = 1'b1;
            wa    = '{j, j % 8};
            wd    = '{32'(j + 1), 32'(j + 1)};
            rand_rd();
            step();
        end
        wen  = 1'b0;
        creq = 1'b1;
        step();
        creq = 1'b0;
        for (int c = 0; c < 40; c++) begin
            wen   = (c == 5);
            wa    = '{3, 3};
            wd    = '{32'h33, 32'h33};
            ra[0] = '{c % 32, 3, 0, 0};
            ra[1] = '{c % 8, 3, (c + 1) % 8, 7};
            step();
        end
        wen = 1'b0;
        for (int j = 0; j < 32; j++) begin
            ra[0] = '{j, (j + 1) % 32, 0, 0};
            ra[1] = '{j % 8, (j + 3) % 8, (j + 5) % 8, (j + 7) % 8};
            step();
        end

        // Refill, reset at clear cycle 10, then a full clear again.
        for (int j = 0; j < 32; j++) begin
            wen = 1'b1;
            wa  = '{j, j % 8};
            wd  = '{32'hC000_0000 + j, 32'hC00 + j};
            rand_rd();
            step();
        end
        wen  = 1'b0;
        creq = 1'b1;
        step();
        creq = 1'b0;
        repeat (9) begin
            rand_rd();
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) begin
            rand_rd();
            step();
        end
        creq = 1'b1;
        step();
        creq = 1'b0;
        repeat (40) begin
            rand_rd();
            step();
        end

        // Randomized traffic.
        repeat (3000) begin
            rand_in();
            step();
        end
        rst  = 1'b0;
        wen  = 1'b0;
        creq = 1'b0;
        step();

        for (int t = 0; t < 5 && q.size() != 0; t++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
